// File: rtl/attenuation_encoder.sv
// attenuation_encoder
//   Converts a linear amplitude into a 2 dB/step attenuation code by a
//   four-step successive-approximation search over the attenuator level table.
//   It also returns the residual: the amplitude minus the level of the chosen step.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a new amplitude (in_ready=1)
//   SEARCH | one table comparison per cycle, MSB of the code first
//   DONE   | result presented (out_valid=1) until out_ready
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     in_level valid this cycle
//   in_ready     encoder can accept in_level (IDLE only)
//   in_level     linear amplitude, VOLUME_BITS wide
//   out_valid    out_control / out_error valid
//   out_ready    consumer accepts the result
//   out_control  attenuation step, 0 = loudest, 15 = silence
//   out_error    in_level minus level of out_control (never negative)
module attenuation_encoder #(
    parameter int CONTROL_BITS = 4,
    parameter int VOLUME_BITS  = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VOLUME_BITS-1:0]  in_level,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CONTROL_BITS-1:0] out_control,
    output logic [VOLUME_BITS-1:0]  out_error
);

    localparam int NUM_LEVELS = 1 << CONTROL_BITS;
    localparam int STEP_BITS  = $clog2(CONTROL_BITS);
    localparam logic [STEP_BITS-1:0] STEP_LOAD = STEP_BITS'(CONTROL_BITS - 1);

    // L[k] = max(1, floor(MAX * 10^(-k/10))) for all but the last entry, which is 0.
    // Evaluated at elaboration only; the table becomes constants.
    function automatic logic [VOLUME_BITS-1:0] level_fn(input int k);
        real max_r;
        real v;
        if (k >= NUM_LEVELS - 1) begin
            return '0;
        end
        max_r = (2.0 ** VOLUME_BITS) - 1.0;
        v = $floor(max_r * (10.0 ** (-real'(k) / 10.0)));
        if (v < 1.0) begin
            v = 1.0;
        end
        return VOLUME_BITS'($rtoi(v));
    endfunction

    logic [VOLUME_BITS-1:0] level_tbl [NUM_LEVELS];

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_tbl
        localparam logic [VOLUME_BITS-1:0] LV = level_fn(g);
        assign level_tbl[g] = LV;
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [VOLUME_BITS-1:0]  level_q, level_d;
    logic [CONTROL_BITS-1:0] acc_q,   acc_d;
    logic [STEP_BITS-1:0]    step_q,  step_d;
    logic [CONTROL_BITS-1:0] trial;
    logic [CONTROL_BITS-1:0] trial_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            level_q <= '0;
            acc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        acc_d     = acc_q;
        step_d    = step_q;
        trial     = '0;
        trial_idx = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    level_d = in_level;
                    acc_d   = '0;
                    step_d  = STEP_LOAD;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                // The table is descending, so the result is the number of entries
                // above the level; entry trial-1 > level means at least trial entries are.
                trial     = acc_q + (CONTROL_BITS'(1) << step_q);
                trial_idx = trial - CONTROL_BITS'(1);
                if (level_tbl[trial_idx] > level_q) begin
                    acc_d = trial;
                end
                if (step_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    step_d = step_q - STEP_BITS'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    // Outputs read zero outside DONE so reset and in-flight searches show nothing.
    assign out_control = out_valid ? acc_q : '0;
    assign out_error   = out_valid ? (level_q - level_tbl[acc_q]) : '0;

endmodule

// File: tb/tb_attenuation_encoder.sv
module tb_attenuation_encoder;

    localparam int VB = 14;
    localparam int CB = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [VB-1:0] in_level;
    logic          out_valid;
    logic          out_ready;
    logic [CB-1:0] out_control;
    logic [VB-1:0] out_error;

    int checks;
    int failures;

    localparam int LTAB [16] = '{16383, 13013, 10336, 8210, 6522, 5180, 4115, 3268,
                                 2596, 2062, 1638, 1301, 1033, 821, 652, 0};

    attenuation_encoder #(.CONTROL_BITS(CB), .VOLUME_BITS(VB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_level    (in_level),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_control (out_control),
        .out_error   (out_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_ctrl(input int lvl);
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (LTAB[i] > lvl) k++;
        end
        return k;
    endfunction

    function automatic int exp_err(input int lvl);
        return lvl - LTAB[exp_ctrl(lvl)];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion with out_ready high; in_level is scrambled after acceptance.
    task automatic convert(input int lvl, input int ectrl, input int eerr, input string tag);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_level  = VB'(lvl);
        tick();
        in_valid  = 1'b0;
        in_level  = VB'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_ctrl"}, out_control, ectrl);
        check({tag, "_err"}, out_error, eerr);
        tick();
        check({tag, "_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        int n;
        int idx;
        int last;
        bit seen;
        int bb_exp [4];

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_level  = '0;
        out_ready = 1'b0;

        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_ctrl", out_control, 0);
        check("reset_err", out_error, 0);
        #21;
        rst_n = 1'b1;
        tick();

        // Directed thresholds with hand-derived results
        convert(8210,  3, 0,    "thr_8210");
        convert(8209,  4, 1687, "thr_8209");
        convert(652,   14, 0,   "thr_652");
        convert(651,   15, 651, "thr_651");
        convert(16383, 0, 0,    "thr_max");
        convert(0,     15, 0,   "thr_zero");
        convert(1,     15, 1,   "thr_one");

        // Every table edge and its neighbour below
        for (int k = 0; k < 15; k++) begin
            convert(LTAB[k], k, 0, "edge_eq");
            convert(LTAB[k] - 1, exp_ctrl(LTAB[k] - 1), exp_err(LTAB[k] - 1), "edge_below");
        end

        // Strided sweep of the input range
        for (int v = 3; v < 16384; v += 41) begin
            convert(v, exp_ctrl(v), exp_err(v), "sweep");
        end

        // Backpressure: 5000 -> 6/885 held while out_ready is low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_level  = VB'(5000);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("bp_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_ctrl", out_control, 6);
            check("bp_err", out_error, 885);
            check("bp_in_ready", in_ready, 0);
            in_valid = 1'b1;
            in_level = VB'(100);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", {in_ready, out_valid}, 2'b10);
        tick();
        check("bp_no_second", {in_ready, out_valid}, 2'b10);

        // Input mutation during SEARCH
        in_valid = 1'b1;
        in_level = VB'(13013);
        tick();
        in_valid = 1'b0;
        in_level = '0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("mut_latency", n, 4);
        check("mut_ctrl", out_control, 1);
        check("mut_err", out_error, 0);
        tick();

        // Reset in the second SEARCH cycle
        in_valid = 1'b1;
        in_level = VB'(16383);
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_ctrl", out_control, 0);
        check("rst_err", out_error, 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("rst_no_result", seen, 0);
        convert(4115, 6, 0, "post_rst");

        // Back-to-back with in_valid and out_ready held high
        bb_exp[0] = 0;
        bb_exp[1] = 15;
        bb_exp[2] = 0;
        bb_exp[3] = 15;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_level  = VB'(16383);
        idx  = 0;
        last = 0;
        for (int cyc = 1; cyc <= 60 && idx < 4; cyc++) begin
            tick();
            if (out_valid === 1'b1) begin
                check("b2b_ctrl", out_control, bb_exp[idx]);
                if (idx > 0) check("b2b_interval", cyc - last, 6);
                last = cyc;
                idx++;
                in_level = (idx % 2 == 1) ? VB'(0) : VB'(16383);
            end
        end
        check("b2b_count", idx, 4);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
